// File: rtl/tlut_pkg.sv
// Shared types and constants for the programmable branch/jump target table.
package tlut_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  localparam int unsigned REL_STEP = 1;

endpackage

// File: rtl/tlut_mem.sv
// Target table storage: one write port, one combinational read port and a
// per-entry synchronous clear of the valid bit.
module tlut_mem #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int W      = 10
) (
  input  logic              clk_i,
  input  logic              clrEn_i,
  input  logic [ADDR_W-1:0] clrAddr_i,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic              wrRel_i,
  input  logic [W-1:0]      wrValue_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic              rdValid_o,
  output logic              rdRel_o,
  output logic [W-1:0]      rdValue_o
);

  logic         validMem_q [DEPTH];
  logic         relMem_q   [DEPTH];
  logic [W-1:0] valueMem_q [DEPTH];

  // Only the valid bit is cleared; stale rel/value bits are harmless once invalid.
  always_ff @(posedge clk_i) begin
    if (clrEn_i) begin
      validMem_q[clrAddr_i] <= 1'b0;
    end
    if (wrEn_i) begin
      validMem_q[wrAddr_i] <= 1'b1;
      relMem_q[wrAddr_i]   <= wrRel_i;
      valueMem_q[wrAddr_i] <= wrValue_i;
    end
  end

  assign rdValid_o = validMem_q[rdAddr_i];
  assign rdRel_o   = relMem_q[rdAddr_i];
  assign rdValue_o = valueMem_q[rdAddr_i];

endmodule

// File: rtl/target_lut_rw.sv
// Run-time programmable target table for fetch: init/flush sequencer, write-first
// bypass, shared target adder and registered one-cycle lookup result.
module target_lut_rw
  import tlut_pkg::*;
#(
  parameter  int PC_width = 10,
  parameter  int DEPTH    = 64,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Flush,
  input  logic                WrEn,
  input  logic [ADDR_W-1:0]   WrAddr,
  input  logic [PC_width-1:0] WrData,
  input  logic                WrRel,
  input  logic                RdEn,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic [PC_width-1:0] PC,
  output logic                Ready,
  output logic [PC_width-1:0] Target,
  output logic                TargetValid,
  output logic                Hit
);

  typedef struct packed {
    logic                valid;
    logic                rel;
    logic [PC_width-1:0] value;
  } entry_t;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [PC_width-1:0] target_q, target_d;
  logic                targetValid_q, targetValid_d;
  logic                hit_q, hit_d;

  logic                run;
  logic                wrAccept;
  logic                rdAccept;
  entry_t              memEntry;
  entry_t              rdEntry;
  logic [PC_width-1:0] addOperand;
  logic [PC_width-1:0] addSum;

  assign run      = (state_q == RUN);
  assign wrAccept = run & WrEn & ~Flush;
  assign rdAccept = run & RdEn;

  tlut_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .W     (PC_width)
  ) u_mem (
    .clk_i    (Clk),
    .clrEn_i  (~run),
    .clrAddr_i(idx_q),
    .wrEn_i   (wrAccept),
    .wrAddr_i (WrAddr),
    .wrRel_i  (WrRel),
    .wrValue_i(WrData),
    .rdAddr_i (Addr),
    .rdValid_o(memEntry.valid),
    .rdRel_o  (memEntry.rel),
    .rdValue_o(memEntry.value)
  );

  // A same-cycle write to the looked-up entry wins over the stored contents.
  assign rdEntry = (wrAccept && (WrAddr == Addr)) ? entry_t'{1'b1, WrRel, WrData} : memEntry;

  // One adder serves both relative hits (PC + offset) and misses (PC + 1).
  assign addOperand = (rdEntry.valid && rdEntry.rel) ? rdEntry.value : PC_width'(REL_STEP);
  assign addSum     = PC + addOperand;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    target_d      = target_q;
    hit_d         = hit_q;
    targetValid_d = 1'b0;

    case (state_q)
      INIT: begin
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RUN: begin
        if (Flush) begin
          state_d = INIT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        idx_d   = '0;
      end
    endcase

    // A lookup accepted alongside Flush still sees the pre-flush contents.
    if (rdAccept) begin
      targetValid_d = 1'b1;
      hit_d         = rdEntry.valid;
      target_d      = (rdEntry.valid && !rdEntry.rel) ? rdEntry.value : addSum;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= INIT;
      idx_q         <= '0;
      target_q      <= '0;
      targetValid_q <= 1'b0;
      hit_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      target_q      <= target_d;
      targetValid_q <= targetValid_d;
      hit_q         <= hit_d;
    end
  end

  assign Ready       = run;
  assign Target      = target_q;
  assign TargetValid = targetValid_q;
  assign Hit         = hit_q;

endmodule

// File: tb/tb_target_lut_rw.sv
// Scoreboard bench for target_lut_rw: a table model predicts each lookup result,
// queues it at issue time and compares it when TargetValid comes back.
module tb_target_lut_rw;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Flush = 1'b0;
  logic       WrEn = 1'b0;
  logic [5:0] WrAddr = '0;
  logic [9:0] WrData = '0;
  logic       WrRel = 1'b0;
  logic       RdEn = 1'b0;
  logic [5:0] Addr = '0;
  logic [9:0] PC = '0;
  logic       Ready;
  logic [9:0] Target;
  logic       TargetValid;
  logic       Hit;

  target_lut_rw #(
    .PC_width(10),
    .DEPTH   (64)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Flush      (Flush),
    .WrEn       (WrEn),
    .WrAddr     (WrAddr),
    .WrData     (WrData),
    .WrRel      (WrRel),
    .RdEn       (RdEn),
    .Addr       (Addr),
    .PC         (PC),
    .Ready      (Ready),
    .Target     (Target),
    .TargetValid(TargetValid),
    .Hit        (Hit)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [9:0] target;
    logic       hit;
  } exp_t;

  exp_t       expQ[$];
  int         checks = 0;
  int         passed = 0;

  bit         mValid[64];
  bit         mRel[64];
  logic [9:0] mVal[64];
  bit         mReady = 1'b0;
  int         initCnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 64; i++) mValid[i] = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance one edge, then check Ready and any result.
  task automatic applyStimulus(input bit wr, input int wa, input logic [9:0] wd, input bit wrel,
                               input bit rd, input int ra, input logic [9:0] pc, input bit fl);
    exp_t       e;
    exp_t       got;
    bit         acc;
    bit         wrOk;
    bit         v;
    bit         r;
    logic [9:0] val;
    WrEn = wr; WrAddr = 6'(wa); WrData = wd; WrRel = wrel;
    RdEn = rd; Addr = 6'(ra); PC = pc; Flush = fl;
    acc  = mReady && rd;
    wrOk = mReady && wr && !fl;
    if (acc) begin
      if (wrOk && wa == ra) begin
        v = 1'b1; r = wrel; val = wd;
      end else begin
        v = mValid[ra]; r = mRel[ra]; val = mVal[ra];
      end
      e.hit    = v;
      e.target = v ? (r ? pc + val : val) : pc + 10'd1;
      expQ.push_back(e);
    end
    if (wrOk) begin
      mValid[wa] = 1'b1; mRel[wa] = wrel; mVal[wa] = wd;
    end
    @(posedge Clk);
    #1;
    WrEn = 1'b0; RdEn = 1'b0; Flush = 1'b0;
    if (!mReady) begin
      initCnt++;
      if (initCnt == 64) mReady = 1'b1;
    end else if (fl) begin
      mReady  = 1'b0;
      initCnt = 0;
      clearModel();
    end
    checkOutput("ready", 32'(Ready), 32'(mReady));
    checkOutput("tvalid", 32'(TargetValid), 32'(acc));
    if (acc) begin
      got = expQ.pop_front();
      checkOutput("target", 32'(Target), 32'(got.target));
      checkOutput("hit", 32'(Hit), 32'(got.hit));
    end
  endtask

  task automatic idle();
    applyStimulus(0, 0, 10'd0, 0, 0, 0, 10'd0, 0);
  endtask

  task automatic lookup(input int ra, input logic [9:0] pc);
    applyStimulus(0, 0, 10'd0, 0, 1, ra, pc, 0);
  endtask

  task automatic write(input int wa, input logic [9:0] wd, input bit wrel);
    applyStimulus(1, wa, wd, wrel, 0, 0, 10'd0, 0);
  endtask

  task automatic runUntilReady();
    for (int i = 0; i < 100 && !mReady; i++) idle();
  endtask

  // Asserts Reset between edges and checks the outputs clear without a clock.
  task automatic doReset();
    Reset = 1'b1;
    #1;
    checkOutput("rst_ready", 32'(Ready), 32'd0);
    checkOutput("rst_tvalid", 32'(TargetValid), 32'd0);
    checkOutput("rst_target", 32'(Target), 32'd0);
    checkOutput("rst_hit", 32'(Hit), 32'd0);
    @(posedge Clk);
    #1;
    checkOutput("rst_tvalid_edge", 32'(TargetValid), 32'd0);
    Reset = 1'b0;
    RdEn  = 1'b0;
    WrEn  = 1'b0;
    Flush = 1'b0;
    mReady  = 1'b0;
    initCnt = 0;
    clearModel();
    expQ.delete();
  endtask

  initial begin
    clearModel();
    doReset();
    runUntilReady();

    lookup(5, 10'd100);
    write(1, 10'd28, 0);
    lookup(1, 10'd0);
    idle();

    write(5, 10'h3FC, 1);
    lookup(5, 10'd8);
    lookup(5, 10'd2);

    applyStimulus(1, 7, 10'd53, 0, 1, 7, 10'd0, 0);
    lookup(9, 10'h3FF);

    applyStimulus(1, 10, 10'd200, 0, 1, 1, 10'd50, 0);
    lookup(10, 10'd3);

    for (int i = 0; i < 8; i++) lookup(int'($urandom_range(0, 15)), 10'($urandom));

    for (int i = 1; i <= 13; i++) write(i, 10'(i * 7), bit'(i % 2));
    lookup(3, 10'd20);
    applyStimulus(1, 4, 10'd99, 0, 1, 3, 10'd20, 1);
    applyStimulus(1, 2, 10'd77, 0, 1, 2, 10'd0, 0);
    runUntilReady();
    for (int i = 1; i <= 13; i++) lookup(i, 10'(100 + i));

    write(1, 10'd28, 0);
    RdEn = 1'b1; Addr = 6'd1; PC = 10'd9;
    #2;
    doReset();
    runUntilReady();
    lookup(1, 10'd5);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
